// File: rtl/gerador_coordenadas_fonte_if.sv
// gerador_coordenadas_fonte_if: request and sample-stream signals of the source-coordinate generator
interface gerador_coordenadas_fonte_if #(
    parameter int LARGURA_COORD = 10
);
    logic [3:0]               entrada_algoritmo;
    logic [1:0]               entrada_zoom;
    logic [LARGURA_COORD-1:0] x_destino;
    logic [LARGURA_COORD-1:0] y_destino;
    logic                     entrada_valida;
    logic                     entrada_pronta;
    logic [LARGURA_COORD-1:0] x_fonte;
    logic [LARGURA_COORD-1:0] y_fonte;
    logic [3:0]               indice_amostra;
    logic                     ultima_amostra;
    logic                     saida_valida;
    logic                     saida_pronta;
    logic                     erro_config;

    modport master (
        output entrada_algoritmo, entrada_zoom, x_destino, y_destino, entrada_valida, saida_pronta,
        input  entrada_pronta, x_fonte, y_fonte, indice_amostra, ultima_amostra, saida_valida, erro_config
    );

    modport slave (
        input  entrada_algoritmo, entrada_zoom, x_destino, y_destino, entrada_valida, saida_pronta,
        output entrada_pronta, x_fonte, y_fonte, indice_amostra, ultima_amostra, saida_valida, erro_config
    );
endinterface

// File: rtl/gerador_coordenadas_fonte.sv
// gerador_coordenadas_fonte: serialises the source coordinates a zoom algorithm needs,
// one clamped (x,y) pair per valid/ready beat, with sample index and last flag.
module gerador_coordenadas_fonte #(
    parameter int LARGURA_COORD = 10,
    parameter int LARGURA_IMG   = 320,
    parameter int ALTURA_IMG    = 240
) (
    input logic clk,
    input logic reset_n,
    gerador_coordenadas_fonte_if.slave bus
);
    localparam int LE = LARGURA_COORD + 3;
    localparam logic [LE-1:0] X_MAX = LE'(LARGURA_IMG - 1);
    localparam logic [LE-1:0] Y_MAX = LE'(ALTURA_IMG - 1);

    typedef enum logic [1:0] {OCIOSO, EMITINDO, ERRO} estado_t;

    estado_t                  estado, proximo;
    logic [3:0]               alg;
    logic [1:0]               k;
    logic [LARGURA_COORD-1:0] xd, yd;
    logic [3:0]               idx, idx_ultimo;
    logic [1:0]               off_x, off_y;
    logic [LE-1:0]            x_calc, y_calc;
    logic                     aceita, transfere, ultima;

    // Extra 3 bits keep the <<2 of zoom-out and the block offset from overflowing before clamping
    function automatic logic [LE-1:0] mapeia(input logic [3:0] a, input logic [1:0] z,
                                             input logic [LARGURA_COORD-1:0] d, input logic [1:0] off);
        logic [LE-1:0] e;
        e = LE'(d);
        return a == 4'b0001 ? (e + LE'(z == 2'd1 ? 2'd1 : z == 2'd2 ? 2'd2 : 2'd0)) >> z
             : a == 4'b0010 ? e >> z
             : a == 4'b0100 ? e << z
             : a == 4'b1000 ? (e << z) + LE'(off)
             : e;
    endfunction

    always_comb begin
        idx_ultimo = alg == 4'b1000 ? (k == 2'd2 ? 4'd15 : k == 2'd1 ? 4'd3 : 4'd0) : 4'd0;
        off_x      = k == 2'd2 ? idx[1:0] : k == 2'd1 ? {1'b0, idx[0]} : 2'd0;
        off_y      = k == 2'd2 ? idx[3:2] : k == 2'd1 ? {1'b0, idx[1]} : 2'd0;
        x_calc     = mapeia(alg, k, xd, off_x);
        y_calc     = mapeia(alg, k, yd, off_y);
    end

    assign ultima             = idx == idx_ultimo;
    assign aceita             = bus.entrada_valida && bus.entrada_pronta;
    assign transfere          = bus.saida_valida && bus.saida_pronta;
    assign bus.entrada_pronta = reset_n && estado == OCIOSO;
    assign bus.saida_valida   = estado == EMITINDO;
    assign bus.erro_config    = estado == ERRO;
    assign bus.x_fonte        = bus.saida_valida ? LARGURA_COORD'(x_calc > X_MAX ? X_MAX : x_calc) : '0;
    assign bus.y_fonte        = bus.saida_valida ? LARGURA_COORD'(y_calc > Y_MAX ? Y_MAX : y_calc) : '0;
    assign bus.indice_amostra = bus.saida_valida ? idx : 4'd0;
    assign bus.ultima_amostra = bus.saida_valida && ultima;

    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO:   proximo = aceita ? (bus.entrada_zoom == 2'b11 ? ERRO : EMITINDO) : OCIOSO;
            EMITINDO: proximo = transfere && ultima ? OCIOSO : EMITINDO;
            ERRO:     proximo = OCIOSO;
            default:  proximo = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado <= OCIOSO;
            alg    <= '0;
            k      <= '0;
            xd     <= '0;
            yd     <= '0;
            idx    <= '0;
        end else begin
            estado <= proximo;
            if (aceita) begin
                alg <= bus.entrada_algoritmo;
                k   <= bus.entrada_zoom;
                xd  <= bus.x_destino;
                yd  <= bus.y_destino;
                idx <= 4'd0;
            end else if (transfere) begin
                idx <= ultima ? 4'd0 : idx + 4'd1;
            end
        end
    end
endmodule

// File: doc/gerador_coordenadas_fonte.md
Name: gerador_coordenadas_fonte

Overview:
- Sequential source-coordinate generator for the zoom coprocessor.
- Accepts one destination pixel request per handshake and streams the source coordinates the selected algorithm needs, one coordinate pair per cycle, with an index and a last flag.
- Replaces the 16-wide parallel coordinate bus with a serial valid/ready stream, so the downstream memory reader fetches one pixel per beat.
- Generalises coordinate width and image bounds, and adds clamping and configuration-error reporting.

Parameters:
LARGURA_COORD, 10, bit width of all x/y coordinates
LARGURA_IMG, 320, source image width in pixels; x outputs clamp to LARGURA_IMG-1
ALTURA_IMG, 240, source image height in pixels; y outputs clamp to ALTURA_IMG-1

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
entrada_algoritmo  in  4  one-hot: 0001 NN zoom-in, 0010 pixel replication, 0100 NN zoom-out, 1000 block average
entrada_zoom  in  2  00=1x, 01=2x, 10=4x, 11=invalid
x_destino  in  LARGURA_COORD  destination x
y_destino  in  LARGURA_COORD  destination y
entrada_valida  in  1  request valid
entrada_pronta  out  1  block ready to accept a request
x_fonte  out  LARGURA_COORD  source x of current sample
y_fonte  out  LARGURA_COORD  source y of current sample
indice_amostra  out  4  sample index within request, 0..N-1
ultima_amostra  out  1  current sample is the last (index N-1)
saida_valida  out  1  sample valid
saida_pronta  in  1  downstream accepts sample
erro_config  out  1  one-cycle pulse: request rejected (zoom=11)

Behaviour:
- Reset (reset_n=0, asynchronous): state OCIOSO; saida_valida=0, x_fonte=0, y_fonte=0, indice_amostra=0, ultima_amostra=0, erro_config=0, entrada_pronta=0 while reset_n=0. Reset mid-stream abandons the request with no further samples.
- States: OCIOSO, EMITINDO, ERRO.
- entrada_pronta=1 only in OCIOSO. Request accepted on an edge with entrada_valida & entrada_pronta; algorithm, zoom and coordinates are latched.
- Let k=0,1,2 for zoom 00,01,10.
- From OCIOSO:
  - zoom=11 -> ERRO. erro_config=1 for exactly that one cycle, no samples emitted; ERRO -> OCIOSO unconditionally.
  - Otherwise -> EMITINDO. First sample valid the cycle after acceptance (latency 1).
- Sample count N: block average gives (2^k)^2 (1, 4 or 16). Every other mode, including a non-one-hot algorithm, gives N=1.
- Arithmetic per algorithm (done at LARGURA_COORD+3 bits, then clamped):
  - NN zoom-in: x=(x_d + (2^k>>1))>>k, y likewise (round half up).
  - Pixel replication: x=x_d>>k, y=y_d>>k (truncate).
  - NN zoom-out: x=x_d<<k, y=y_d<<k.
  - Block average, sample i: x=(x_d<<k)+(i mod 2^k), y=(y_d<<k)+(i div 2^k). Row-major order: i=0 is top-left, i increments along x first.
  - Non-one-hot algorithm (fallback): x=x_d, y=y_d.
- Clamping: x>LARGURA_IMG-1 outputs LARGURA_IMG-1; y>ALTURA_IMG-1 outputs ALTURA_IMG-1. Clamping never alters N.
- Output handshake: a sample transfers on an edge with saida_valida & saida_pronta. While saida_valida=1 and saida_pronta=0, x_fonte, y_fonte, indice_amostra and ultima_amostra hold stable. With saida_pronta held high, throughput is one sample per cycle.
- On transfer of a sample with ultima_amostra=1: EMITINDO -> OCIOSO and saida_valida=0 the next cycle. A new request is therefore accepted at most every N+1 cycles.
- entrada_* changes during EMITINDO have no effect on the stream in progress.

Test Plan:
- Reset: assert reset_n=0 mid-block-average stream (sample 5 of 16) -> all outputs 0 immediately. After release, entrada_pronta=1 and no stale samples appear.
- NN zoom-in, zoom=01, x_d=7, y_d=4 -> single sample x=4, y=2, index 0, ultima=1 one cycle after acceptance. Pixel replication, same inputs -> x=3, y=2.
- Block average, zoom=10, x_d=2, y_d=1, saida_pronta=1 -> 16 consecutive samples, (8,4),(9,4),(10,4),(11,4),(8,5)...(11,7), indices 0..15, ultima only on 15. entrada_pronta returns the cycle after.
- Backpressure: block average zoom=01, x_d=0, y_d=0, saida_pronta toggled 1,0,0,1,1,0,1 -> exactly (0,0),(1,0),(0,1),(1,1) in order, each held stable while stalled.
- Clamp: NN zoom-out, zoom=10, x_d=100, y_d=70 (defaults) -> x=319, y=239, N=1.
- Error/fallback: zoom=11 with any algorithm -> erro_config pulse of 1 cycle, saida_valida stays 0, entrada_pronta high again 1 cycle later. Algorithm 0011, x_d=5, y_d=9 -> single sample (5,9).
